// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the memory responder: FSM state encoding,
// word geometry and the wait-state counter width.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int WORD_BYTES = 4;

    // ceil(log2(n)), but never less than 1 so a zero-wait build still has a counter bit
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'd1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage: asynchronous instruction read port, registered data read port
// and a synchronous write port. Contents are not reset.
module mem_array #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic [ADDR_WIDTH-1:0] iaddr_i,
    output logic [31:0]           idata_o,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [31:0]           rd_data_o,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [31:0]           wr_data_i
);

    logic [31:0] mem_q [2**ADDR_WIDTH];
    logic [31:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign idata_o   = mem_q[iaddr_i];
    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: combinational instruction fetch plus a data port that
// completes each load/store after WAIT_STATES wait cycles and gates the PC via mem_ready.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_addr,
    output logic [31:0] instr,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    input  logic        ctrl_mem_read,
    input  logic        ctrl_mem_write,
    output logic [31:0] data_out,
    output logic        mem_ready,
    output logic        busy,
    output logic        addr_err
);

    localparam int OFS = $clog2(WORD_BYTES);
    localparam int HI  = ADDR_WIDTH + OFS - 1;
    localparam int CW  = cnt_width(WAIT_STATES + 1);
    localparam logic [CW-1:0] CNT_INIT = (WAIT_STATES == 0) ? '0 : CW'(WAIT_STATES - 1);

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  ok_q, ok_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  is_write_q, is_write_d;
    logic                  conflict_q, conflict_d;
    logic                  busy_q;
    logic                  addr_err_q;
    logic                  rd_zero_q;

    logic                  req;
    logic                  inst_ok;
    logic [31:0]           inst_word;
    logic                  data_ok;
    logic [ADDR_WIDTH-1:0] data_idx;
    logic                  acc_ok;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic [31:0]           acc_wdata;
    logic                  acc_write;
    logic                  acc_conflict;
    logic                  enter_done;
    logic                  mem_we;
    logic                  mem_re;
    logic [31:0]           mem_rdata;
    logic                  unused_byte_bits;

    assign req      = ctrl_mem_read | ctrl_mem_write;
    assign inst_ok  = (inst_addr[31:HI+1] == '0);
    assign data_ok  = (data_addr[31:HI+1] == '0);
    assign data_idx = data_addr[HI:OFS];
    assign unused_byte_bits = ^{inst_addr[OFS-1:0], data_addr[OFS-1:0]};

    // Completion straight from IDLE (zero wait states) uses the live inputs, otherwise the latched copy.
    assign acc_ok       = (state_q == IDLE) ? data_ok        : ok_q;
    assign acc_idx      = (state_q == IDLE) ? data_idx       : idx_q;
    assign acc_wdata    = (state_q == IDLE) ? data_in        : wdata_q;
    assign acc_write    = (state_q == IDLE) ? ctrl_mem_write : is_write_q;
    assign acc_conflict = (state_q == IDLE) ? (ctrl_mem_read & ctrl_mem_write) : conflict_q;
    assign enter_done   = (state_d == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            ok_q       <= 1'b0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            conflict_q <= 1'b0;
            busy_q     <= 1'b0;
            addr_err_q <= 1'b0;
            rd_zero_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            ok_q       <= ok_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            conflict_q <= conflict_d;
            busy_q     <= (state_d != IDLE);
            addr_err_q <= enter_done & (~acc_ok | acc_conflict);
            if (enter_done && !acc_write) begin
                rd_zero_q <= ~acc_ok;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        ok_d       = ok_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        conflict_d = conflict_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d      = data_idx;
                    ok_d       = data_ok;
                    wdata_d    = data_in;
                    is_write_d = ctrl_mem_write;
                    conflict_d = ctrl_mem_read & ctrl_mem_write;
                    cnt_d      = CNT_INIT;
                    state_d    = (WAIT_STATES == 0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // rst gates the array strobes since the array itself has no reset.
    always_comb begin
        mem_ready = ((state_q == IDLE) & ~req) | (state_q == DONE);
        mem_we    = enter_done & acc_write & acc_ok & ~rst;
        mem_re    = enter_done & ~acc_write & acc_ok & ~rst;
    end

    mem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem_array (
        .clk_i     (clk),
        .iaddr_i   (inst_addr[HI:OFS]),
        .idata_o   (inst_word),
        .rd_en_i   (mem_re),
        .rd_addr_i (acc_idx),
        .rd_data_o (mem_rdata),
        .wr_en_i   (mem_we),
        .wr_addr_i (acc_idx),
        .wr_data_i (acc_wdata)
    );

    assign instr    = inst_ok ? inst_word : 32'h0000_0000;
    assign data_out = rd_zero_q ? 32'h0000_0000 : mem_rdata;
    assign busy     = busy_q;
    assign addr_err = addr_err_q;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the single-cycle processor's instruction and data ports.
- Instruction port: combinational word read, so the processor fetches in the same cycle.
- Data port: a small FSM with WAIT_STATES wait states per access, returning read data and completing writes.
- Drives mem_ready, which the top level ties to the processor's pc_enable so the PC holds until a load or store completes.

Parameters:
- ADDR_WIDTH, 10, word-index bits; storage is 2^ADDR_WIDTH x 32-bit words.
- WAIT_STATES, 1, extra cycles per data access before completion; 0 is legal.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- inst_addr  input  32  instruction byte address from the processor.
- instr  output  32  instruction word, combinational.
- data_addr  input  32  data byte address (ALU result).
- data_in  input  32  write data from the processor (rt register).
- ctrl_mem_read  input  1  load request, level, held by the processor while stalled.
- ctrl_mem_write  input  1  store request, level, held while stalled.
- data_out  output  32  load data, registered.
- mem_ready  output  1  PC advance permitted this cycle; connects to pc_enable.
- busy  output  1  registered, high when state is not IDLE.
- addr_err  output  1  registered one-cycle pulse in DONE for an out-of-range or conflicting access.

Behaviour:
- Addressing:
  - Word index = addr[ADDR_WIDTH+1:2]; bits [1:0] ignored (no byte lanes).
  - Address is in range iff addr[31:ADDR_WIDTH+2] == 0.
- Instruction port:
  - instr = mem[inst_addr index] combinationally.
  - Out-of-range inst_addr returns 32'h0000_0000 (a NOP); no error raised.
- Data FSM states: IDLE, WAIT, DONE.
  - IDLE: req = ctrl_mem_read | ctrl_mem_write.
    - If req: latch addr, wdata and is_write (is_write = ctrl_mem_write; write wins when both are high, and conflict is flagged).
    - Next state is WAIT with counter = WAIT_STATES-1, or DONE if WAIT_STATES == 0.
  - WAIT: counter decrements each cycle. Exits to DONE on the edge where counter == 0. Input changes during WAIT are ignored; latched values are used.
  - Edge entering DONE:
    - Write: commit mem[idx] = wdata if in range; out-of-range writes are dropped.
    - Read: data_out = mem[idx], or 0 if out of range.
    - addr_err is set for that DONE cycle if out of range or conflict, otherwise 0.
  - DONE: lasts exactly one cycle, then IDLE unconditionally. The processor advances its PC on this edge, so a still-asserted request belongs to the next instruction.
- mem_ready = (state == IDLE & !req) | (state == DONE). Combinational, no latency. Every load/store therefore stalls the PC for WAIT_STATES+1 cycles.
- data_out holds its last value outside DONE.
- Same-cycle visibility: in DONE and later, instr and data reads of a just-written word return the new value.
- Reset (any time, including mid-access):
  - state = IDLE, counter = 0, data_out = 0, busy = 0, addr_err = 0.
  - A pending write is discarded.
  - Memory contents are not cleared.
  - While rst is high and req is high, mem_ready = 0.
- Back-to-back accesses: DONE→IDLE→WAIT. Each access restarts from IDLE and there is no pipelining.

Decomposition:
- Shared package mem_resp_pkg:
  - state enum {IDLE, WAIT, DONE}.
  - WORD_BYTES = 4.
  - Counter width function clog2(WAIT_STATES+1), with a minimum of 1.
- One sub-module, mem_array: 2^ADDR_WIDTH x 32 storage with one asynchronous read port (instruction), one synchronous read port and one synchronous write port (data). No reset on the array.
- The FSM, counter and latches live in mem_responder.

Test Plan:
- WAIT_STATES=1. Store data_addr=0x10, data_in=0xDEADBEEF, ctrl_mem_write=1 from IDLE:
  - mem_ready=0 for 2 cycles, then 1 in DONE; busy=1 in WAIT and DONE.
  - A subsequent load of 0x10 yields data_out=0xDEADBEEF in its DONE cycle, with addr_err=0.
- WAIT_STATES=0. Load of 0x14 preloaded with 0x12345678:
  - mem_ready=0 for exactly 1 cycle.
  - data_out=0x12345678 in the DONE cycle.
- Out-of-range store to 0x0000_1000 (ADDR_WIDTH=10), data 0xFFFFFFFF:
  - addr_err=1 for one cycle in DONE.
  - Word 0 is unchanged on readback.
- Both ctrl_mem_read and ctrl_mem_write high, addr 0x20, data 0xA5A5A5A5:
  - The write commits (word 0x20 reads back 0xA5A5A5A5).
  - addr_err=1 in DONE.
- Assert rst in the WAIT cycle of a store of 0x55 to 0x24:
  - state=IDLE, data_out=0, busy=0 immediately.
  - Readback of 0x24 returns its pre-reset value, not 0x55.
- Drive inst_addr=0x10 during the DONE cycle of the store of 0xCAFEF00D to 0x10:
  - instr=0xCAFEF00D in that cycle.
  - inst_addr=0xFFFF_0000 gives instr=0x00000000.
